// File: rtl/snes_input_arbiter.sv
// rtl/snes_input_arbiter.sv - three-source controller arbiter driving a SNES serial pad line
module snes_input_arbiter #(
    parameter int HOLD_CYCLES   = 2080,
    parameter int FRAME_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] button_data,
    input  logic [15:0] keyboard_data,
    input  logic [15:0] ir_data,
    input  logic        snes_latch,
    input  logic        snes_clk,
    output logic        serial_out,
    output logic [1:0]  owner,
    output logic        frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0] OWN_IR   = 2'b00;
    localparam logic [1:0] OWN_KB   = 2'b01;
    localparam logic [1:0] OWN_BTN  = 2'b10;
    localparam logic [1:0] OWN_NONE = 2'b11;

    localparam int IW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [IW-1:0] HOLD_MAX = IW'(HOLD_CYCLES);
    localparam logic [TW-1:0] TO_LAST  = TW'(FRAME_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [2:0]      latch_sync_q, latch_sync_d;
    logic [2:0]      clk_sync_q, clk_sync_d;
    logic [1:0]      owner_q, owner_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [15:0]     shift_q, shift_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic            serial_q, serial_d;
    logic            frame_done_q, frame_done_d;

    logic            latch_rise, latch_fall, sclk_rise;
    logic [15:0]     owned_word;
    logic [1:0]      best_src;
    logic [4:0]      bit_cnt_inc;

    // Bits [1:0] are the two-flop synchroniser; bit [2] is the previous synchronised value for edge detect
    always_comb begin
        latch_sync_d = {latch_sync_q[1:0], snes_latch};
        clk_sync_d   = {clk_sync_q[1:0], snes_clk};
    end

    assign latch_rise  =  latch_sync_q[1] & ~latch_sync_q[2];
    assign latch_fall  = ~latch_sync_q[1] &  latch_sync_q[2];
    assign sclk_rise   =  clk_sync_q[1]   & ~clk_sync_q[2];
    assign bit_cnt_inc = bit_cnt_q + 5'd1;

    // Word of the current owner and the highest-priority active source
    always_comb begin
        owned_word = 16'h0000;
        case (owner_q)
            OWN_IR:  owned_word = ir_data;
            OWN_KB:  owned_word = keyboard_data;
            OWN_BTN: owned_word = button_data;
            default: owned_word = 16'h0000;
        endcase
        best_src = OWN_NONE;
        if (button_data != 16'h0000)        best_src = OWN_BTN;
        else if (keyboard_data != 16'h0000) best_src = OWN_KB;
        else if (ir_data != 16'h0000)       best_src = OWN_IR;
    end

    // Ownership: idle counting always runs; owner only changes outside an active frame
    always_comb begin
        owner_d    = owner_q;
        idle_cnt_d = idle_cnt_q;
        if (owner_q == OWN_NONE) begin
            idle_cnt_d = '0;
        end else if (owned_word == 16'h0000) begin
            if (idle_cnt_q != HOLD_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = '0;
        end
        if (state_q == S_IDLE || state_q == S_DONE) begin
            if (owner_q == OWN_NONE) begin
                owner_d = best_src;
            end else if (idle_cnt_q == HOLD_MAX) begin
                owner_d    = best_src;
                idle_cnt_d = '0;
            end
        end
    end

    // Frame FSM: latch edges load the shifter, console clock edges shift it out
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        to_cnt_d     = to_cnt_q;
        frame_done_d = 1'b0;
        if (latch_rise) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: begin
                    shift_d   = owned_word;
                    bit_cnt_d = 5'd0;
                    to_cnt_d  = '0;
                    if (latch_fall) state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (sclk_rise) begin
                        shift_d   = {1'b0, shift_q[15:1]};
                        bit_cnt_d = bit_cnt_inc;
                        to_cnt_d  = '0;
                        if (bit_cnt_inc == 5'd16) begin
                            state_d      = S_DONE;
                            frame_done_d = 1'b1;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        case (state_d)
            S_IDLE:  serial_d = 1'b1;
            S_DONE:  serial_d = 1'b0;
            default: serial_d = ~shift_d[0];
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            latch_sync_q <= 3'b000;
            clk_sync_q   <= 3'b000;
            owner_q      <= OWN_NONE;
            idle_cnt_q   <= '0;
            to_cnt_q     <= '0;
            shift_q      <= 16'h0000;
            bit_cnt_q    <= 5'd0;
            serial_q     <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            latch_sync_q <= latch_sync_d;
            clk_sync_q   <= clk_sync_d;
            owner_q      <= owner_d;
            idle_cnt_q   <= idle_cnt_d;
            to_cnt_q     <= to_cnt_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            serial_q     <= serial_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign serial_out = serial_q;
    assign owner      = owner_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_snes_input_arbiter.sv
// tb/tb_snes_input_arbiter.sv - directed vector bench for snes_input_arbiter
module tb_snes_input_arbiter;

    localparam int HOLD = 20;
    localparam int TOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] button_data = 16'h0, keyboard_data = 16'h0, ir_data = 16'h0;
    logic        snes_latch = 1'b0, snes_clk = 1'b0;
    logic        serial_out, frame_done;
    logic [1:0]  owner;

    int tests = 0;
    int fails = 0;
    int fd_cnt = 0;

    snes_input_arbiter #(.HOLD_CYCLES(HOLD), .FRAME_TIMEOUT(TOUT)) dut (
        .clk(clk), .reset(reset),
        .button_data(button_data), .keyboard_data(keyboard_data), .ir_data(ir_data),
        .snes_latch(snes_latch), .snes_clk(snes_clk),
        .serial_out(serial_out), .owner(owner), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) fd_cnt++;

    typedef struct {
        logic [15:0] btn;
        logic [15:0] kb;
        logic [15:0] ir;
        logic [1:0]  exp_owner;
        logic [15:0] exp_bits;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic latch_pulse();
        snes_latch = 1'b1; cycles(4);
        snes_latch = 1'b0; cycles(4);
    endtask

    task automatic clk_pulse();
        snes_clk = 1'b1; cycles(4);
        snes_clk = 1'b0; cycles(4);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b0;
        cycles(2); reset = 1'b1;
    endtask

    task automatic run_frame(output logic [15:0] bits, output int fds);
        int fd0;
        fd0 = fd_cnt;
        latch_pulse();
        for (int i = 0; i < 16; i++) begin
            bits[i] = serial_out;
            clk_pulse();
        end
        fds = fd_cnt - fd0;
    endtask

    vec_t vecs[5];

    initial begin
        logic [15:0] bits;
        int          fds, fd0;
        bit          seen;

        vecs[0] = '{16'h0001, 16'h0000, 16'h0000, 2'b10, 16'hFFFE};
        vecs[1] = '{16'hA5A5, 16'hFFFF, 16'hFFFF, 2'b10, 16'h5A5A};
        vecs[2] = '{16'h0000, 16'h1234, 16'hFFFF, 2'b01, 16'hEDCB};
        vecs[3] = '{16'h0000, 16'h0000, 16'h8001, 2'b00, 16'h7FFE};
        vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 2'b11, 16'hFFFF};

        // reset state
        #12;
        check("reset_serial", {31'd0, serial_out}, 32'd1);
        check("reset_owner", {30'd0, owner}, 32'd3);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        cycles(2); reset = 1'b1;

        // vector table: one full frame per source mix
        foreach (vecs[v]) begin
            do_reset();
            button_data = vecs[v].btn; keyboard_data = vecs[v].kb; ir_data = vecs[v].ir;
            cycles(3);
            check($sformatf("vec%0d_owner", v), {30'd0, owner}, {30'd0, vecs[v].exp_owner});
            run_frame(bits, fds);
            check($sformatf("vec%0d_bits", v), {16'd0, bits}, {16'd0, vecs[v].exp_bits});
            check($sformatf("vec%0d_frame_done", v), fds, 32'd1);
            check($sformatf("vec%0d_serial_done", v), {31'd0, serial_out}, 32'd0);
        end

        // priority and hold-time release
        do_reset();
        button_data = 16'h0001; keyboard_data = 16'h8000; ir_data = 16'h0001;
        cycles(3);
        check("prio_owner_btn", {30'd0, owner}, 32'd2);
        button_data = 16'h0000;
        cycles(HOLD - 2);
        check("hold_not_yet", {30'd0, owner}, 32'd2);
        cycles(6);
        check("hold_released_kb", {30'd0, owner}, 32'd1);
        run_frame(bits, fds);
        check("kb_frame_bits", {16'd0, bits}, 32'h7FFF);
        check("kb_frame_bit15", {31'd0, bits[15]}, 32'd0);

        // release falls due mid-frame: owner frozen until DONE
        keyboard_data = 16'h0000; button_data = 16'h0002;
        latch_pulse();
        for (int i = 0; i < 15; i++) clk_pulse();
        check("freeze_mid_frame", {30'd0, owner}, 32'd1);
        snes_clk = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check("freeze_done_seen", {31'd0, seen}, 32'd1);
        check("freeze_owner_at_done", {30'd0, owner}, 32'd1);
        @(negedge clk);
        check("freeze_owner_switched", {30'd0, owner}, 32'd2);
        snes_clk = 1'b0; cycles(4);

        // timeout: frame abandoned with no pulse
        button_data = 16'hFFFF;
        fd0 = fd_cnt;
        latch_pulse();
        for (int i = 0; i < 5; i++) clk_pulse();
        check("timeout_in_shift", {31'd0, serial_out}, 32'd0);
        cycles(TOUT + 10);
        check("timeout_idle_serial", {31'd0, serial_out}, 32'd1);
        check("timeout_no_frame_done", fd_cnt - fd0, 32'd0);

        // latch and console clock rising together: reload wins
        button_data = 16'h0001;
        latch_pulse();
        check("coll_bit0", {31'd0, serial_out}, 32'd0);
        for (int i = 0; i < 3; i++) clk_pulse();
        check("coll_bit3", {31'd0, serial_out}, 32'd1);
        snes_latch = 1'b1; snes_clk = 1'b1; cycles(4);
        snes_latch = 1'b0; snes_clk = 1'b0; cycles(4);
        check("coll_bit0_again", {31'd0, serial_out}, 32'd0);
        clk_pulse();
        check("coll_bit1", {31'd0, serial_out}, 32'd1);

        // reset mid-frame, then a clean frame
        cycles(TOUT + 10);
        fd0 = fd_cnt;
        latch_pulse();
        for (int i = 0; i < 8; i++) clk_pulse();
        reset = 1'b0;
        #1;
        check("midreset_serial", {31'd0, serial_out}, 32'd1);
        check("midreset_owner", {30'd0, owner}, 32'd3);
        check("midreset_no_fd", fd_cnt - fd0, 32'd0);
        cycles(2); reset = 1'b1;
        cycles(3);
        check("post_reset_owner", {30'd0, owner}, 32'd2);
        run_frame(bits, fds);
        check("post_reset_bits", {16'd0, bits}, 32'hFFFE);
        check("post_reset_fd", fds, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
